// File: rtl/instr_loader.sv
// instr_loader: assembles big-endian 32-bit instruction words from a received
// byte stream and writes them sequentially into instruction memory. Loading
// stops on the HALT word or when the last memory address has been written.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for i_start, rx bytes ignored
// ST_RECV  | shifting bytes into the current word (first byte -> [31:24])
// ST_WRITE | one-cycle memory write of the assembled word
// ST_DONE  | load finished (HALT or memory full), waiting for i_start
module instr_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH:0]   CNT_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]            state;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] word_sr;
  logic [DATA_WIDTH-1:0] word_shifted;

  // Incoming byte enters at the bottom so the first byte ends up in the top byte.
  always_comb begin
    word_shifted = {word_sr[DATA_WIDTH-BYTE_WIDTH-1:0], i_rx_data};
  end

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      addr         <= '0;
      word_sr      <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // A start in the same cycle as a byte wins; the byte is not kept.
          if (i_start) begin
            state        <= ST_RECV;
            byte_cnt     <= '0;
            addr         <= '0;
            o_word_count <= '0;
            o_overflow   <= 1'b0;
            o_done       <= 1'b0;
            o_busy       <= 1'b1;
          end
        end
        ST_RECV: begin
          if (i_rx_valid) begin
            word_sr <= word_shifted;
            if (byte_cnt == 2'd3) begin
              state     <= ST_WRITE;
              byte_cnt  <= '0;
              o_wr_en   <= 1'b1;
              o_wr_addr <= addr;
              o_wr_data <= word_shifted;
              if (o_word_count != CNT_MAX) begin
                o_word_count <= o_word_count + 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          // HALT is checked first so a HALT at the last address is not an overflow.
          if (o_wr_data == HALT_WORD) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (addr == ADDR_LAST) begin
            state      <= ST_DONE;
            o_done     <= 1'b1;
            o_busy     <= 1'b0;
            o_overflow <= 1'b1;
          end else begin
            state <= ST_RECV;
            addr  <= addr + 1'b1;
            // A byte arriving during the write cycle starts the next word.
            if (i_rx_valid) begin
              word_sr  <= word_shifted;
              byte_cnt <= 2'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
